hdd_request_ctrl: RTL and testbench
===================================

# hdd_request_ctrl

Parametrised block-device request controller. It turns per-unit sector read/write requests from the IIgs core into MiSTer host SD requests (`sd_lba`/`sd_rd`/`sd_wr`/`sd_ack`) and drives a per-unit CPU wait. It generalises the single-drive HDD handshake to `UNITS` drives sharing one `sd_buff` path. It adds:
- round-robin arbitration between units
- mount and write-protect checking with an error return
- an ack timeout

## Interface
Parameters:
- `UNITS`, 2: number of block units; sd channel index == unit index.
- `SECTOR_W`, 16: width of each requested sector number.
- `LBA_W`, 32: width of each `sd_lba` lane; must be >= `SECTOR_W`.
- `TIMEOUT`, 0: cycles to wait for the `sd_ack` rise; 0 disables the timeout.

Ports:
- `clk_sys`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `req_sector`  in  `UNITS*SECTOR_W`  sector for unit u, lane u; sampled with the request.
- `req_read`  in  `UNITS`  one-cycle read request pulse per unit.
- `req_write`  in  `UNITS`  one-cycle write request pulse per unit.
- `cpu_wait`  out  `UNITS`  unit u has a pending or active request.
- `done`  out  `UNITS`  one-cycle pulse: transfer completed.
- `err`  out  `UNITS`  one-cycle pulse: request rejected or timed out.
- `img_mounted`  in  `UNITS`  host mount strobe per unit.
- `img_readonly`  in  1  read-only flag, valid with `img_mounted`.
- `img_size`  in  64  image size, valid with `img_mounted`.
- `mounted`  out  `UNITS`  unit has a non-empty image.
- `protect`  out  `UNITS`  unit is write-protected.
- `sd_lba`  out  `UNITS*LBA_W`  host LBA per unit, lane u.
- `sd_rd`  out  `UNITS`  host read request.
- `sd_wr`  out  `UNITS`  host write request.
- `sd_ack`  in  `UNITS`  host acknowledge, high for the whole buffer transfer.

## Operation
- **Reset values:** all outputs are 0, `sd_lba` lanes included. Pending latches, sector latches and the state machine clear. The round-robin pointer resets to 0.
- **Mount:**
  - In any cycle with `img_mounted[u]` = 1: `mounted[u]` <= (`img_size` != 0) and `protect[u]` <= `img_readonly`.
  - Mount state is not cleared by `reset`; it powers up as 0.
- **Request capture:**
  - `req_read[u]` sets `rd_pend[u]`; `req_write[u]` sets `wr_pend[u]`.
  - `req_sector` lane u is latched on either request.
  - A request for a unit that already has something pending or active is merged: the pending bit is ORed in and the sector is overwritten only if the unit is not active.
- **Arbiter FSM**, one shared instance. States: IDLE, REQ, XFER.
  - **IDLE:** scan units starting at the pointer; the first unit with a pending bit becomes `g`.
    - If `mounted[g]` = 0, or write-only pending with `protect[g]` = 1: clear the offending pending bits, pulse `err[g]`, stay in IDLE.
    - Otherwise choose the operation. Read wins if both bits are pending; the write stays pending for a later grant.
    - Drive `sd_lba[g]` = zero-extended sector, assert `sd_rd[g]` or `sd_wr[g]`, clear that pending bit, go to REQ.
    - The pointer moves to g+1 (mod `UNITS`) on every grant or rejection.
  - **REQ:**
    - On `sd_ack[g]` rise (`sd_ack[g]` & ~`ack_q[g]`): drop `sd_rd[g]`/`sd_wr[g]` and go to XFER.
    - If `TIMEOUT` != 0 and the counter reaches `TIMEOUT`: drop the request, pulse `err[g]`, go to IDLE.
  - **XFER:** on `sd_ack[g]` fall: pulse `done[g]`, go to IDLE.
- **Wait:** `cpu_wait[u]` = registered (`rd_pend[u]` | `wr_pend[u]` | (state != IDLE & g == u)).
- **Stray acks:** acks on non-granted units are ignored.
- **Protected write in a mixed request:** when a read and a write are both pending and `protect` = 1, the read is granted; the write is rejected on its own later turn.

## Timing
- Request pulse at edge N -> pending at N+1 -> `cpu_wait[u]` at N+2.
- If IDLE at N+1: `sd_rd`/`sd_wr` and `sd_lba` valid at N+2.
- `ack_q` is `sd_ack` delayed by one cycle.
- Ack rise sampled at edge A -> `sd_rd`/`sd_wr` low at A+1.
- Ack fall sampled at edge F -> `done` high for F+1 only. `cpu_wait` low at F+2 if nothing else is pending for that unit.
- Rejection: `err` pulses one cycle after the IDLE scan selects the unit. `cpu_wait` low the cycle after that.
- Timeout counter: starts at 0 on entry to REQ and increments each REQ cycle.
- Back-to-back: the next grant can issue the cycle after returning to IDLE.
- Reset mid-transfer: everything returns to reset values at the next edge. A host ack in progress is ignored until it falls.

## Test plan
- **Single read:** unit 0 mounted, `req_read[0]` with sector 0x0123 -> `sd_lba[0]` = 0x00000123, `sd_rd[0]` = 1 two cycles later. Ack high 10 cycles then low -> `sd_rd` drops one cycle after the rise, one `done[0]` pulse, `cpu_wait[0]` falls.
- **Arbitration:** `req_read` on units 0 and 1 in the same cycle -> unit 0 served first, unit 1 `sd_rd` only after unit 0 `done`. Repeat -> unit 1 served first (round robin).
- **Protection:** `protect[1]` = 1, `req_write[1]` -> no `sd_wr[1]`, one `err[1]` pulse. Read + write in the same cycle -> read transfer completes, then `err[1]`.
- **Unmounted:** `img_size` = 0 mount then a request -> `err`, no `sd_rd`.
- **Timeout:** `TIMEOUT` = 16, no ack -> `sd_rd` high exactly 16 cycles, then `err` and return to IDLE.
- **Reset mid-XFER:** reset during ack -> all outputs 0 next cycle; a new request after the ack falls completes normally.

Source files
------------

// File: rtl/hdd_request_ctrl.sv
// hdd_request_ctrl: multi-unit block request controller bridging core sector
// requests onto host SD lanes with round-robin arbitration, mount/protect
// checking and an optional ack timeout.
module hdd_request_ctrl #(
  parameter int unsigned UNITS    = 2,
  parameter int unsigned SECTOR_W = 16,
  parameter int unsigned LBA_W    = 32,
  parameter int unsigned TIMEOUT  = 0
) (
  input  logic                      clk_sys,
  input  logic                      reset,
  input  logic [UNITS*SECTOR_W-1:0] req_sector,
  input  logic [UNITS-1:0]          req_read,
  input  logic [UNITS-1:0]          req_write,
  output logic [UNITS-1:0]          cpu_wait,
  output logic [UNITS-1:0]          done,
  output logic [UNITS-1:0]          err,
  input  logic [UNITS-1:0]          img_mounted,
  input  logic                      img_readonly,
  input  logic [63:0]               img_size,
  output logic [UNITS-1:0]          mounted,
  output logic [UNITS-1:0]          protect,
  output logic [UNITS*LBA_W-1:0]    sd_lba,
  output logic [UNITS-1:0]          sd_rd,
  output logic [UNITS-1:0]          sd_wr,
  input  logic [UNITS-1:0]          sd_ack
);

  localparam int unsigned IDX_W = (UNITS > 1) ? $clog2(UNITS) : 1;
  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_XFER
  } state_t;

  state_t               state_q, state_n;
  logic [IDX_W-1:0]     g_q, g_n;
  logic [IDX_W-1:0]     ptr_q, ptr_n;
  logic [CNT_W-1:0]     cnt_q, cnt_n;
  logic [UNITS-1:0]     rd_pend, wr_pend;
  logic [UNITS-1:0]     rd_clr, wr_clr;
  logic [UNITS-1:0]     ack_q;
  logic [UNITS-1:0]     active;
  logic [UNITS-1:0]     sd_rd_n, sd_wr_n, done_n, err_n;
  logic [SECTOR_W-1:0]  sector_q [UNITS];
  logic [LBA_W-1:0]     lba_q [UNITS];
  logic [LBA_W-1:0]     lba_n [UNITS];
  logic                 scan_hit;
  logic [IDX_W-1:0]     scan_sel;
  logic [IDX_W-1:0]     cand;
  logic [IDX_W-1:0]     sel_next;
  logic [CNT_W-1:0]     cnt_inc;

  // Unit currently owning the arbiter (granted and not yet back in IDLE).
  always_comb begin
    active = '0;
    for (int u = 0; u < int'(UNITS); u++) begin
      active[u] = (state_q != ST_IDLE) && (g_q == IDX_W'(u));
    end
  end

  // Round-robin scan: first unit with a pending bit, starting at the pointer.
  always_comb begin
    scan_hit = 1'b0;
    scan_sel = '0;
    cand     = '0;
    for (int i = 0; i < int'(UNITS); i++) begin
      cand = IDX_W'((32'(ptr_q) + 32'(i)) % UNITS);
      if (!scan_hit && (rd_pend[cand] || wr_pend[cand])) begin
        scan_hit = 1'b1;
        scan_sel = cand;
      end
    end
    sel_next = (scan_sel == IDX_W'(UNITS - 1)) ? '0 : scan_sel + IDX_W'(1);
  end

  // Arbiter next-state, grant/reject decisions and registered-output next values.
  always_comb begin
    state_n = state_q;
    g_n     = g_q;
    ptr_n   = ptr_q;
    cnt_n   = cnt_q;
    rd_clr  = '0;
    wr_clr  = '0;
    sd_rd_n = sd_rd;
    sd_wr_n = sd_wr;
    done_n  = '0;
    err_n   = '0;
    cnt_inc = cnt_q + CNT_W'(1);
    for (int u = 0; u < int'(UNITS); u++) begin
      lba_n[u] = lba_q[u];
    end

    case (state_q)
      ST_IDLE: begin
        if (scan_hit) begin
          ptr_n = sel_next;
          if (!mounted[scan_sel]) begin
            // No image: drop everything pending for this unit.
            rd_clr[scan_sel] = 1'b1;
            wr_clr[scan_sel] = 1'b1;
            err_n[scan_sel]  = 1'b1;
          end else if (rd_pend[scan_sel]) begin
            // Read wins; a write pending alongside waits for a later turn.
            rd_clr[scan_sel]  = 1'b1;
            sd_rd_n[scan_sel] = 1'b1;
            lba_n[scan_sel]   = LBA_W'(sector_q[scan_sel]);
            g_n               = scan_sel;
            cnt_n             = '0;
            state_n           = ST_REQ;
          end else if (protect[scan_sel]) begin
            wr_clr[scan_sel] = 1'b1;
            err_n[scan_sel]  = 1'b1;
          end else begin
            wr_clr[scan_sel]  = 1'b1;
            sd_wr_n[scan_sel] = 1'b1;
            lba_n[scan_sel]   = LBA_W'(sector_q[scan_sel]);
            g_n               = scan_sel;
            cnt_n             = '0;
            state_n           = ST_REQ;
          end
        end
      end

      ST_REQ: begin
        if (sd_ack[g_q] && !ack_q[g_q]) begin
          sd_rd_n[g_q] = 1'b0;
          sd_wr_n[g_q] = 1'b0;
          state_n      = ST_XFER;
        end else if ((TIMEOUT != 0) && (cnt_inc == CNT_W'(TIMEOUT))) begin
          sd_rd_n[g_q] = 1'b0;
          sd_wr_n[g_q] = 1'b0;
          err_n[g_q]   = 1'b1;
          state_n      = ST_IDLE;
        end else begin
          cnt_n = cnt_inc;
        end
      end

      ST_XFER: begin
        if (!sd_ack[g_q] && ack_q[g_q]) begin
          done_n[g_q] = 1'b1;
          state_n     = ST_IDLE;
        end
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Arbiter state, host request lines and status pulses.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      g_q      <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
      ack_q    <= '0;
      sd_rd    <= '0;
      sd_wr    <= '0;
      done     <= '0;
      err      <= '0;
      cpu_wait <= '0;
    end else begin
      state_q  <= state_n;
      g_q      <= g_n;
      ptr_q    <= ptr_n;
      cnt_q    <= cnt_n;
      ack_q    <= sd_ack;
      sd_rd    <= sd_rd_n;
      sd_wr    <= sd_wr_n;
      done     <= done_n;
      err      <= err_n;
      cpu_wait <= rd_pend | wr_pend | active;
    end
  end

  // Pending latches: new requests OR in, arbiter clears what it consumes.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      rd_pend <= '0;
      wr_pend <= '0;
    end else begin
      rd_pend <= (rd_pend & ~rd_clr) | req_read;
      wr_pend <= (wr_pend & ~wr_clr) | req_write;
    end
  end

  // Mount status survives reset; power-up value comes from register init.
  always_ff @(posedge clk_sys) begin
    for (int u = 0; u < int'(UNITS); u++) begin
      if (img_mounted[u]) begin
        mounted[u] <= (img_size != 64'd0);
        protect[u] <= img_readonly;
      end
    end
  end

  for (genvar u = 0; u < int'(UNITS); u++) begin : g_lane
    // Sector latch; frozen while this unit owns the host channel.
    always_ff @(posedge clk_sys) begin
      if (reset) begin
        sector_q[u] <= '0;
      end else if ((req_read[u] || req_write[u]) && !active[u]) begin
        sector_q[u] <= req_sector[u*SECTOR_W +: SECTOR_W];
      end
    end

    // Host LBA lane register.
    always_ff @(posedge clk_sys) begin
      if (reset) begin
        lba_q[u] <= '0;
      end else begin
        lba_q[u] <= lba_n[u];
      end
    end

    assign sd_lba[u*LBA_W +: LBA_W] = lba_q[u];
  end

endmodule

// File: tb/tb_hdd_request_ctrl.sv
// Scoreboard bench for hdd_request_ctrl: a host model acks requests, a monitor
// turns DUT output activity into events compared against an expected queue.
module tb_hdd_request_ctrl;

  localparam int unsigned UNITS = 2;
  localparam int EV_RD   = 1;
  localparam int EV_WR   = 2;
  localparam int EV_DONE = 3;
  localparam int EV_ERR  = 4;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [31:0] req_sector;
  logic [1:0]  req_read;
  logic [1:0]  req_write;
  logic [1:0]  cpu_wait;
  logic [1:0]  done;
  logic [1:0]  err;
  logic [1:0]  img_mounted;
  logic        img_readonly;
  logic [63:0] img_size;
  logic [1:0]  mounted;
  logic [1:0]  protect;
  logic [63:0] sd_lba;
  logic [1:0]  sd_rd;
  logic [1:0]  sd_wr;
  logic [1:0]  sd_ack = '0;

  int n_checks = 0;
  int n_pass   = 0;
  bit host_en  = 1'b1;
  logic [63:0] exp_q [$];
  logic [1:0]  prev_rd = '0;
  logic [1:0]  prev_wr = '0;

  hdd_request_ctrl #(
    .UNITS(2), .SECTOR_W(16), .LBA_W(32), .TIMEOUT(16)
  ) dut (
    .clk_sys(clk_sys), .reset(reset),
    .req_sector(req_sector), .req_read(req_read), .req_write(req_write),
    .cpu_wait(cpu_wait), .done(done), .err(err),
    .img_mounted(img_mounted), .img_readonly(img_readonly), .img_size(img_size),
    .mounted(mounted), .protect(protect),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [63:0] ev(input int k, input int u, input logic [31:0] lba);
    return {16'd0, 8'(k), 8'(u), lba};
  endfunction

  task automatic got_ev(input logic [63:0] e);
    logic [63:0] x;
    if (exp_q.size() == 0) begin
      check("unexpected_event", e, 64'd0);
    end else begin
      x = exp_q.pop_front();
      check("event", e, x);
    end
  endtask

  // Monitor: request rises, done and err pulses become scoreboard events.
  always @(negedge clk_sys) begin
    for (int u = 0; u < 2; u++) begin
      if (sd_rd[u] && !prev_rd[u]) got_ev(ev(EV_RD, u, sd_lba[u*32 +: 32]));
      if (sd_wr[u] && !prev_wr[u]) got_ev(ev(EV_WR, u, sd_lba[u*32 +: 32]));
      if (done[u]) got_ev(ev(EV_DONE, u, 32'd0));
      if (err[u])  got_ev(ev(EV_ERR, u, 32'd0));
    end
    prev_rd = sd_rd;
    prev_wr = sd_wr;
  end

  task automatic serve(input int u);
    repeat (2) @(negedge clk_sys);
    sd_ack[u] = 1'b1;
    @(negedge clk_sys);
    check("req_drop_after_ack", 64'(sd_rd[u] | sd_wr[u]), 64'd0);
    repeat (9) @(negedge clk_sys);
    sd_ack[u] = 1'b0;
  endtask

  // Host model: acknowledge a raised request, hold ack for 10 cycles.
  always begin
    @(negedge clk_sys);
    if (host_en) begin
      for (int u = 0; u < 2; u++) begin
        if ((sd_rd[u] || sd_wr[u]) && !sd_ack[u]) serve(u);
      end
    end
  end

  task automatic issue(input logic [1:0] rd, input logic [1:0] wr,
                       input logic [15:0] s0, input logic [15:0] s1);
    req_sector = {s1, s0};
    req_read   = rd;
    req_write  = wr;
    @(negedge clk_sys);
    req_read   = '0;
    req_write  = '0;
  endtask

  task automatic mount(input logic [1:0] m, input logic ro, input logic [63:0] size);
    img_mounted  = m;
    img_readonly = ro;
    img_size     = size;
    @(negedge clk_sys);
    img_mounted  = '0;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while ((exp_q.size() != 0 || cpu_wait != 2'b00 || sd_ack != 2'b00) && k < 300) begin
      @(negedge clk_sys);
      k++;
    end
    check(tag, 64'(k < 300), 64'd1);
    repeat (2) @(negedge clk_sys);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rdwr"}, 64'({sd_rd, sd_wr}), 64'd0);
    check({tag, "_pulses"}, 64'({done, err}), 64'd0);
    check({tag, "_wait"}, 64'(cpu_wait), 64'd0);
    check({tag, "_lba"}, sd_lba, 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int hi;
    reset = 1'b1;
    req_sector = '0; req_read = '0; req_write = '0;
    img_mounted = '0; img_readonly = 1'b0; img_size = '0;
    repeat (3) @(negedge clk_sys);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk_sys);

    // Mount both units writable.
    mount(2'b11, 1'b0, 64'd1000);
    check("mounted_both", 64'(mounted), 64'd3);
    check("protect_none", 64'(protect), 64'd0);

    // Single read with latency checks.
    exp_q.push_back(ev(EV_RD, 0, 32'h0000_0123));
    exp_q.push_back(ev(EV_DONE, 0, 32'd0));
    issue(2'b01, 2'b00, 16'h0123, 16'h0000);
    check("rd_lat_1", 64'(sd_rd[0]), 64'd0);
    @(negedge clk_sys);
    check("rd_lat_2", 64'(sd_rd[0]), 64'd1);
    check("lba_lane0", 64'(sd_lba[31:0]), 64'h123);
    check("wait_up", 64'(cpu_wait[0]), 64'd1);
    wait_idle("idle_single");

    // Single read unit 1 (pointer back to 0 afterwards).
    exp_q.push_back(ev(EV_RD, 1, 32'h0000_0042));
    exp_q.push_back(ev(EV_DONE, 1, 32'd0));
    issue(2'b10, 2'b00, 16'h0000, 16'h0042);
    wait_idle("idle_u1");

    // Simultaneous reads, pointer at 0: unit 0 first.
    exp_q.push_back(ev(EV_RD, 0, 32'h0000_0200));
    exp_q.push_back(ev(EV_DONE, 0, 32'd0));
    exp_q.push_back(ev(EV_RD, 1, 32'h0000_0300));
    exp_q.push_back(ev(EV_DONE, 1, 32'd0));
    issue(2'b11, 2'b00, 16'h0200, 16'h0300);
    wait_idle("idle_pair_a");

    // Single write unit 0 moves the pointer to 1.
    exp_q.push_back(ev(EV_WR, 0, 32'h0000_0055));
    exp_q.push_back(ev(EV_DONE, 0, 32'd0));
    issue(2'b00, 2'b01, 16'h0055, 16'h0000);
    wait_idle("idle_write");

    // Simultaneous reads, pointer at 1: unit 1 first.
    exp_q.push_back(ev(EV_RD, 1, 32'h0000_0500));
    exp_q.push_back(ev(EV_DONE, 1, 32'd0));
    exp_q.push_back(ev(EV_RD, 0, 32'h0000_0400));
    exp_q.push_back(ev(EV_DONE, 0, 32'd0));
    issue(2'b11, 2'b00, 16'h0400, 16'h0500);
    wait_idle("idle_pair_b");

    // Write-protect unit 1; a write is rejected.
    mount(2'b10, 1'b1, 64'd1000);
    check("protect_u1", 64'(protect), 64'd2);
    check("mounted_u1_ro", 64'(mounted), 64'd3);
    exp_q.push_back(ev(EV_ERR, 1, 32'd0));
    issue(2'b00, 2'b10, 16'h0000, 16'h0066);
    wait_idle("idle_prot_wr");

    // Mixed read+write on protected unit: read completes, then write rejected.
    exp_q.push_back(ev(EV_RD, 1, 32'h0000_0077));
    exp_q.push_back(ev(EV_DONE, 1, 32'd0));
    exp_q.push_back(ev(EV_ERR, 1, 32'd0));
    issue(2'b10, 2'b10, 16'h0000, 16'h0077);
    wait_idle("idle_mixed");

    // Empty image on unit 0: read rejected.
    mount(2'b01, 1'b0, 64'd0);
    check("unmounted_u0", 64'(mounted), 64'd2);
    exp_q.push_back(ev(EV_ERR, 0, 32'd0));
    issue(2'b01, 2'b00, 16'h0011, 16'h0000);
    wait_idle("idle_unmounted");

    // Timeout: no ack, request held exactly 16 cycles then err.
    host_en = 1'b0;
    exp_q.push_back(ev(EV_RD, 1, 32'h0000_0fed));
    exp_q.push_back(ev(EV_ERR, 1, 32'd0));
    issue(2'b10, 2'b00, 16'h0000, 16'h0fed);
    k = 0;
    while (!sd_rd[1] && k < 10) begin @(negedge clk_sys); k++; end
    check("to_rd_seen", 64'(sd_rd[1]), 64'd1);
    hi = 0;
    while (sd_rd[1] && hi < 40) begin hi++; @(negedge clk_sys); end
    check("to_len", 64'(hi), 64'd16);
    wait_idle("idle_timeout");
    host_en = 1'b1;

    // Reset in the middle of a transfer.
    mount(2'b01, 1'b0, 64'd1000);
    exp_q.push_back(ev(EV_RD, 0, 32'h0000_0999));
    exp_q.push_back(ev(EV_DONE, 0, 32'd0));
    issue(2'b01, 2'b00, 16'h0999, 16'h0000);
    k = 0;
    while (!sd_ack[0] && k < 50) begin @(negedge clk_sys); k++; end
    check("rst_ack_seen", 64'(sd_ack[0]), 64'd1);
    repeat (3) @(negedge clk_sys);
    reset = 1'b1;
    @(negedge clk_sys);
    check_all_zero("mid_reset");
    reset = 1'b0;
    check("rst_q_left", 64'(exp_q.size()), 64'd1);
    exp_q.delete();
    k = 0;
    while (sd_ack[0] && k < 50) begin @(negedge clk_sys); k++; end
    repeat (2) @(negedge clk_sys);
    check("rst_pulses_quiet", 64'({done, err}), 64'd0);
    exp_q.push_back(ev(EV_RD, 0, 32'h0000_0abc));
    exp_q.push_back(ev(EV_DONE, 0, 32'd0));
    issue(2'b01, 2'b00, 16'h0abc, 16'h0000);
    wait_idle("idle_after_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
